alu_rr_scheduler: RTL and testbench

- Shares one 8-bit ALU datapath between NREQ independent requesters.
- Each requester presents an operand pair and an opcode under a valid/ready handshake.
- A round-robin arbiter grants one request per cycle and computes the result with the team's standard 8-bit ALU opcode set.
- The result is returned through a single-entry registered response port tagged with the winning requester ID; the block sits between requester engines and the shared ALU resource.

---
 rtl/alu_rr_scheduler.sv | 127 ++++++++++++
 tb/tb_alu_rr_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Shares one 8-bit ALU among NREQ requesters via a round-robin grant and a
// single-entry registered response port with a saturating completion counter.
module alu_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ*3-1:0] req_oper,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_result,
    output logic [CNTW-1:0]   op_count
);
    localparam int DATA_W = 8;

    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    ptr_nxt;
    logic [IDW-1:0]    win;
    logic [IDW-1:0]    win_hi;
    logic [IDW-1:0]    win_lo;
    logic              found_hi;
    logic              found_lo;
    logic              can_accept;
    logic              xfer;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [2:0]        op_p0;
    logic              vld_p1;
    logic [IDW-1:0]    id_p1;
    logic [DATA_W-1:0] result_p1;
    logic [CNTW-1:0]   cnt;

    function automatic logic [DATA_W-1:0] alu(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [2:0]        op);
        logic [DATA_W:0] r;
        case (op)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {1'b0, a} - {1'b0, b};
            3'b010:  r = {1'b0, b} - {1'b0, a};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, a & b};
            3'b101:  r = {1'b0, a ^ b};
            3'b110:  r = {1'b0, a ~^ b};
            default: r = '0;
        endcase
        return r[DATA_W-1:0];
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Stage p0: round-robin search; the lowest valid index at or above the
    // pointer wins, otherwise the lowest valid index overall (wrap-around).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found_lo = 1'b1;
                win_lo   = IDW'(i);
                if (i >= int'(ptr)) begin
                    found_hi = 1'b1;
                    win_hi   = IDW'(i);
                end
            end
        end
    end

    assign win        = found_hi ? win_hi : win_lo;
    assign can_accept = !vld_p1 || rsp_ready;
    assign xfer       = found_lo && can_accept;
    assign req_ready  = xfer ? (NREQ'(1) << win) : '0;
    assign ptr_nxt    = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;

    always_comb begin
        a_p0  = '0;
        b_p0  = '0;
        op_p0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                a_p0  = req_a[i*DATA_W +: DATA_W];
                b_p0  = req_b[i*DATA_W +: DATA_W];
                op_p0 = req_oper[i*3 +: 3];
            end
        end
    end

    // Stage p1: response register; a completion and a new transfer in the
    // same cycle simply reload it, keeping one operation per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            id_p1     <= '0;
            result_p1 <= '0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            if (xfer) begin
                vld_p1    <= 1'b1;
                id_p1     <= win;
                result_p1 <= alu(a_p0, b_p0, op_p0);
                ptr       <= ptr_nxt;
            end else if (rsp_ready) begin
                vld_p1    <= 1'b0;
            end
            if (vld_p1 && rsp_ready) begin
                cnt <= sat_inc(cnt);
            end
        end
    end

    assign rsp_valid  = vld_p1;
    assign rsp_id     = id_p1;
    assign rsp_result = result_p1;
    assign op_count   = cnt;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Randomised self-checking bench for alu_rr_scheduler against a cycle-level
// behavioural model; a second CNTW=4 instance exercises counter saturation.
module tb_alu_rr_scheduler;
    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_oper;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_result;
    logic [15:0] op_count;
    logic [3:0]  s_ready;
    logic        s_valid;
    logic [1:0]  s_id;
    logic [7:0]  s_result;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    int m_ptr, m_vld, m_id, m_res, m_cnt;

    alu_rr_scheduler #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_oper(req_oper), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .op_count(op_count)
    );

    alu_rr_scheduler #(.NREQ(4), .IDW(2), .CNTW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_ready),
        .req_a(req_a), .req_b(req_b), .req_oper(req_oper), .rsp_valid(s_valid),
        .rsp_ready(rsp_ready), .rsp_id(s_id), .rsp_result(s_result), .op_count(s_cnt)
    );

    always #5 clk = ~clk;

    function automatic int alu_ref(int a, int b, int op);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return (b - a + 256) % 256;
            3: return a | b;
            4: return a & b;
            5: return a ^ b;
            6: return (~(a ^ b)) & 255;
            default: return 0;
        endcase
    endfunction

    function automatic int fld(logic [31:0] v, int i, int w);
        return int'((v >> (w * i)) & ((32'd1 << w) - 32'd1));
    endfunction

    function automatic int m_winner();
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (((req_valid >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        int w;
        w = m_winner();
        if ((m_vld == 0 || rsp_ready) && w >= 0) return 4'(1 << w);
        return 4'd0;
    endfunction

    function automatic int sat15(int c);
        return (c > 15) ? 15 : c;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_vld = 0; m_id = 0; m_res = 0; m_cnt = 0;
    endtask

    // Advance one clock; the model consumes the inputs that were present at the edge.
    task automatic tick();
        int w;
        bit ca;
        @(posedge clk);
        ca = (m_vld == 0) || rsp_ready;
        w  = m_winner();
        if (m_vld != 0 && rsp_ready) m_cnt = m_cnt + 1;
        if (ca && w >= 0) begin
            m_res = alu_ref(fld(req_a, w, 8), fld(req_b, w, 8), fld(32'(req_oper), w, 3));
            m_id  = w;
            m_vld = 1;
            m_ptr = (w + 1) % NR;
        end else if (rsp_ready) begin
            m_vld = 0;
        end
        #1;
    endtask

    task automatic set_req(int i, int va, int vb, int vop);
        req_a    = (req_a & ~(32'hFF << (8 * i))) | (32'(va & 255) << (8 * i));
        req_b    = (req_b & ~(32'hFF << (8 * i))) | (32'(vb & 255) << (8 * i));
        req_oper = 12'((32'(req_oper) & ~(32'h7 << (3 * i))) | (32'(vop & 7) << (3 * i)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_oper = '0; rsp_ready = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 8'h00 || op_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b id=%0d result=%h count=%0d, required all zero",
                     rsp_valid, rsp_id, rsp_result, op_count);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b, required 0000 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_single();
        req_valid = 4'b0001; set_req(0, 8'h0F, 8'h01, 0); rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_ready: got %b required 0001", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 8'h10) begin
            errors++;
            $display("FAIL single_rsp: valid=%b id=%0d result=%h, required 1 0 10", rsp_valid, rsp_id, rsp_result);
        end
        req_valid = 4'b0000;
        tick();
        checks++;
        if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_count: count=%0d valid=%b, required 1 0", op_count, rsp_valid);
        end
    endtask

    task automatic test_opcodes();
        int ta [5] = '{8'hFF, 8'h05, 8'h03, 8'hF0, 8'hAB};
        int tb [5] = '{8'h01, 8'h03, 8'h05, 8'h3C, 8'h5D};
        int to [5] = '{0, 2, 1, 6, 7};
        int te [5] = '{8'h00, 8'hFE, 8'hFE, 8'h33, 8'h00};
        for (int k = 0; k < 5; k++) begin
            req_valid = 4'b0100; set_req(2, ta[k], tb[k], to[k]);
            #1;
            checks++;
            if (req_ready !== 4'b0100) begin
                errors++; $display("FAIL opcode_ready[%0d]: got %b required 0100", k, req_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || int'(rsp_result) != te[k] || int'(rsp_result) != m_res) begin
                errors++;
                $display("FAIL opcode_rsp[%0d]: valid=%b id=%0d result=%h, required 1 2 %h", k,
                         rsp_valid, rsp_id, rsp_result, te[k]);
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, $urandom, $urandom, $urandom_range(0, 7));
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << (k % 4)) || req_ready !== m_ready()) begin
                errors++; $display("FAIL fair_grant[%0d]: got %b required %b", k, req_ready, 4'(1 << (k % 4)));
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || int'(rsp_id) != k % 4 || int'(rsp_result) != m_res) begin
                errors++;
                $display("FAIL fair_rsp[%0d]: valid=%b id=%0d result=%h, required 1 %0d %h", k,
                         rsp_valid, rsp_id, rsp_result, k % 4, m_res[7:0]);
            end
            set_req(k % 4, $urandom, $urandom, $urandom_range(0, 7));
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] hid;
        logic [7:0] hres;
        req_valid = 4'b1010; rsp_ready = 1'b0;
        hid = rsp_id; hres = rsp_result;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b required 0000", k, req_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== hid || rsp_result !== hres || int'(rsp_id) != m_id) begin
                errors++;
                $display("FAIL bp_hold[%0d]: id=%0d result=%h, required %0d %h", k, rsp_id, rsp_result, hid, hres);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_release: ready=%b required 0010", req_ready);
        end
        tick();
        checks++;
        if (rsp_id !== 2'd1 || int'(rsp_result) != m_res) begin
            errors++; $display("FAIL bp_rsp: id=%0d result=%h, required 1 %h", rsp_id, rsp_result, m_res[7:0]);
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0; req_valid = 4'b0110;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 8'h00 || op_count !== 16'd0 || s_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b id=%0d result=%h count=%0d, required all zero",
                     rsp_valid, rsp_id, rsp_result, op_count);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010 || req_ready !== m_ready()) begin
            errors++; $display("FAIL post_reset_grant: got %b required 0010", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || int'(rsp_result) != m_res) begin
            errors++; $display("FAIL post_reset_rsp: valid=%b id=%0d, required 1 1", rsp_valid, rsp_id);
        end
    endtask

    task automatic test_random();
        logic [3:0] acc;
        acc = 4'b1111;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (((req_valid >> i) & 4'd1) == 4'd0 || ((acc >> i) & 4'd1) != 4'd0) begin
                    if ($urandom_range(0, 2) != 0) req_valid = req_valid | 4'(1 << i);
                    else req_valid = req_valid & ~4'(1 << i);
                    set_req(i, $urandom, $urandom, $urandom_range(0, 7));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (req_ready !== m_ready() || s_ready !== m_ready()) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b required %b", c, req_ready, m_ready());
            end
            acc = req_ready;
            tick();
            checks++;
            if (int'(rsp_valid) != m_vld || (m_vld != 0 && (int'(rsp_id) != m_id || int'(rsp_result) != m_res))
                || int'(op_count) != m_cnt || int'(s_cnt) != sat15(m_cnt)) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: valid=%b id=%0d result=%h count=%0d, required %0d %0d %h %0d",
                         c, rsp_valid, rsp_id, rsp_result, op_count, m_vld, m_id, m_res[7:0], m_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 22; k++) begin
            tick();
            checks++;
            if (int'(s_cnt) != sat15(m_cnt) || int'(op_count) != m_cnt) begin
                errors++;
                $display("FAIL sat_count[%0d]: small=%0d wide=%0d, required %0d %0d", k, s_cnt, op_count,
                         sat15(m_cnt), m_cnt);
            end
        end
        rsp_ready = 1'b0; req_valid = 4'b0000;
        repeat (2) tick();
        checks++;
        if (s_cnt !== 4'hF || op_count !== 16'd21) begin
            errors++; $display("FAIL sat_final: small=%h wide=%0d, required F 21", s_cnt, op_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_opcodes();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
